booth_essential_encoder: RTL and testbench
==========================================

BOOTH_ESSENTIAL_ENCODER -- requirements
Module: booth_essential_encoder

Interface
REQ-001 SHALL have port clk, input, 1 bit: single clock, rising edge.
REQ-002 SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-003 SHALL have port in_valid, input, 1 bit: operand presented.
REQ-004 SHALL have port in_ready, output, 1 bit: encoder idle; operand accepted when in_valid && in_ready at a rising edge.
REQ-005 SHALL have port operand, input, 16 bits: two's-complement operand to recode.
REQ-006 SHALL have port out_valid, output, 1 bit: recoded result available.
REQ-007 SHALL have port out_ready, input, 1 bit: consumer takes result when out_valid && out_ready at a rising edge.
REQ-008 SHALL have port BPR, output, 24 bits (8 slots x 3): packed radix-4 Booth triples, slot k at [3k+2:3k].
REQ-009 SHALL have port BPR_POS, output, 24 bits (8 slots x 3): source group index of each slot.
REQ-010 SHALL have port ETC, output, 4 bits: essential term count, 0..8.

Function
REQ-011 Group i (0..7) triple SHALL be {operand[2i+1], operand[2i], operand[2i-1]}, with operand[-1]=0; the triple is emitted unmodified (011=+2, 100=-2, 101/110=-1, 001/010=+1).
REQ-012 Triples 000 and 111 SHALL be non-essential; all other triples are essential.
REQ-013 Essential triples SHALL be packed in ascending group order from slot 0; BPR_POS slot k = group index of BPR slot k.
REQ-014 Unused slots (k >= ETC) SHALL hold BPR=000 and BPR_POS=000.
REQ-015 ETC SHALL equal the number of essential triples.
REQ-016 FSM states SHALL be IDLE, SCAN, DONE; in_ready = (state==IDLE).
REQ-017 IDLE: on accept, latch operand, clear BPR/BPR_POS/ETC, set group index to 0, go to SCAN.
REQ-018 SCAN: exactly one group per cycle; an essential triple is written to slot ETC and ETC increments; after group 7, go to DONE.
REQ-019 Without the macro in REQ-026, out_valid SHALL first be high exactly 8 cycles after the accepting edge.
REQ-020 DONE: out_valid=1; BPR, BPR_POS and ETC SHALL be held stable while out_ready=0.
REQ-021 DONE with out_ready=1 SHALL return to IDLE, dropping out_valid; there is no overlap of a new accept with DONE (one-cycle bubble).
REQ-022 in_valid and operand changes SHALL be ignored outside IDLE.
REQ-023 out_valid SHALL be 0 in IDLE and SCAN; BPR/BPR_POS/ETC are don't-care there, but are driven from registers only.

Reset
REQ-024 Assertion of reset at any time, including mid-SCAN or DONE, SHALL immediately force IDLE, out_valid=0, in_ready=1 after release, BPR=0, BPR_POS=0, ETC=0, group index=0.
REQ-025 The first accept SHALL be possible on the first rising edge after reset deasserts.

Configuration
REQ-026 Macro PAMAC_BPR_EARLY_TERM_EN defined: in SCAN, after processing group i, if operand[15:2i+1] is all zeros or all ones, go to DONE immediately (remaining triples are non-essential); latency = (last processed group + 1) cycles, minimum 1.
REQ-027 Macro undefined: fixed 8-cycle SCAN for every operand; results identical to the defined case.

Verification
REQ-028 operand=16'h0000 -> ETC=0, BPR=0, BPR_POS=0; latency 8 (1 with macro).
REQ-029 operand=16'h0006 -> ETC=2, slot0=100 pos0, slot1=011 pos1, other slots 0.
REQ-030 operand=16'hFFFF -> ETC=1, slot0=110 pos0; with macro, out_valid 1 cycle after accept.
REQ-031 operand=16'h5555 -> ETC=8, all slots 010, BPR_POS slots = 0..7; latency 8 in both builds.
REQ-032 out_ready held 0 for 5 cycles in DONE -> outputs stable, in_ready=0, in_valid ignored; out_ready=1 -> IDLE next cycle, next accept the following cycle.
REQ-033 reset pulse at SCAN group 3 -> outputs 0 and IDLE; a subsequent operand=16'h0001 yields ETC=1, slot0=010.

Source files
------------

// File: rtl/booth_essential_encoder.sv
// Radix-4 Booth recoder: scans one group per cycle and packs the essential triples into the low slots.
// Optional early termination when the remaining operand bits are pure sign extension: PAMAC_BPR_EARLY_TERM_EN.
module booth_essential_encoder (
   input  logic        clk,
   input  logic        reset,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [15:0] operand,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [23:0] BPR,
   output logic [23:0] BPR_POS,
   output logic [3:0]  ETC
);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_SCAN = 2'd1;
   localparam logic [1:0] S_DONE = 2'd2;

   logic [1:0]  state_q, state_d;
   logic [15:0] op_q, op_d;
   logic [2:0]  grp_q, grp_d;
   logic [23:0] bpr_q, bpr_d;
   logic [23:0] pos_q, pos_d;
   logic [3:0]  etc_q, etc_d;

   logic [16:0] ext;
   logic [4:0]  bit_idx;
   logic [2:0]  triple;
   logic        essential;
   logic [4:0]  slot_base;
   logic        scan_last;

   // The appended zero supplies operand[-1] for group 0.
   assign ext       = {op_q, 1'b0};
   assign bit_idx   = {1'b0, grp_q, 1'b0};
   assign triple    = ext[bit_idx +: 3];
   assign essential = (triple != 3'b000) && (triple != 3'b111);
   assign slot_base = {2'b00, etc_q[2:0]} * 5'd3;

`ifdef PAMAC_BPR_EARLY_TERM_EN
   logic signed [15:0] upper;
   logic [3:0]         sh;
   // Once operand[15:2i+1] is all-equal, every later triple is 000 or 111.
   assign sh        = {grp_q, 1'b0} + 4'd1;
   assign upper     = $signed(op_q) >>> sh;
   assign scan_last = (grp_q == 3'd7) || (&upper) || (~|upper);
`else
   assign scan_last = (grp_q == 3'd7);
`endif

   always_comb begin
      state_d = state_q;
      op_d    = op_q;
      grp_d   = grp_q;
      bpr_d   = bpr_q;
      pos_d   = pos_q;
      etc_d   = etc_q;
      case (state_q)
         S_IDLE: begin
            if (in_valid) begin
               op_d    = operand;
               bpr_d   = '0;
               pos_d   = '0;
               etc_d   = '0;
               grp_d   = '0;
               state_d = S_SCAN;
            end
         end
         S_SCAN: begin
            if (essential) begin
               bpr_d[slot_base +: 3] = triple;
               pos_d[slot_base +: 3] = grp_q;
               etc_d                 = etc_q + 4'd1;
            end
            grp_d = grp_q + 3'd1;
            if (scan_last) begin
               state_d = S_DONE;
            end
         end
         S_DONE: begin
            if (out_ready) begin
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= S_IDLE;
         op_q    <= '0;
         grp_q   <= '0;
         bpr_q   <= '0;
         pos_q   <= '0;
         etc_q   <= '0;
      end else begin
         state_q <= state_d;
         op_q    <= op_d;
         grp_q   <= grp_d;
         bpr_q   <= bpr_d;
         pos_q   <= pos_d;
         etc_q   <= etc_d;
      end
   end

   assign in_ready  = (state_q == S_IDLE);
   assign out_valid = (state_q == S_DONE);
   assign BPR       = bpr_q;
   assign BPR_POS   = pos_q;
   assign ETC       = etc_q;

endmodule

// File: tb/tb_booth_essential_encoder.sv
// Self-checking bench for booth_essential_encoder: directed corner operands, reset mid-scan, then random operands.
module tb_booth_essential_encoder;

   logic        clk = 1'b0;
   logic        reset;
   logic        in_valid;
   logic        in_ready;
   logic [15:0] operand;
   logic        out_valid;
   logic        out_ready;
   logic [23:0] BPR;
   logic [23:0] BPR_POS;
   logic [3:0]  ETC;

   int checks = 0;
   int errors = 0;

   booth_essential_encoder dut (
      .clk       (clk),
      .reset     (reset),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .operand   (operand),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .BPR       (BPR),
      .BPR_POS   (BPR_POS),
      .ETC       (ETC)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Reference: walk the eight overlapping bit-triples of operand*2 and compact the non-uniform ones.
   task automatic model(input logic [15:0] op, output logic [23:0] bpr, output logic [23:0] pos,
                        output logic [3:0] etc, output int lat);
      int n;
      int ext;
      int t;
      int p;
      n   = 0;
      ext = int'(op) * 2;
      bpr = '0;
      pos = '0;
      for (int g = 0; g < 8; g++) begin
         t = (ext >> (2 * g)) & 7;
         if (t != 0 && t != 7) begin
            bpr[3*n +: 3] = t[2:0];
            pos[3*n +: 3] = g[2:0];
            n++;
         end
      end
      etc = n[3:0];
      p = -1;
      for (int j = 0; j < 15; j++) begin
         if (op[j] != op[15]) p = j;
      end
`ifdef PAMAC_BPR_EARLY_TERM_EN
      lat = (p + 1) / 2 + 1;
`else
      lat = 8;
`endif
   endtask

   task automatic run_op(input logic [15:0] op, input int hold);
      logic [23:0] e_bpr;
      logic [23:0] e_pos;
      logic [3:0]  e_etc;
      int          e_lat;
      int          first;
      model(op, e_bpr, e_pos, e_etc, e_lat);
      for (int k = 0; k < 20 && !in_ready; k++) begin
         @(posedge clk); #1;
      end
      chk("in_ready_idle", 32'(in_ready), 32'd1);
      in_valid = 1'b1;
      operand  = op;
      @(posedge clk); #1;
      in_valid = 1'b0;
      operand  = 16'($urandom);
      chk("scan_out_valid", 32'(out_valid), 32'd0);
      chk("scan_in_ready", 32'(in_ready), 32'd0);
      first = -1;
      for (int c = 1; c <= 20; c++) begin
         @(posedge clk); #1;
         if (out_valid) begin
            first = c;
            break;
         end
      end
      chk("latency", 32'(first), 32'(e_lat));
      chk("bpr", 32'(BPR), 32'(e_bpr));
      chk("bpr_pos", 32'(BPR_POS), 32'(e_pos));
      chk("etc", 32'(ETC), 32'(e_etc));
      for (int h = 0; h < hold; h++) begin
         in_valid = 1'b1;
         operand  = 16'($urandom);
         @(posedge clk); #1;
         chk("hold_out_valid", 32'(out_valid), 32'd1);
         chk("hold_in_ready", 32'(in_ready), 32'd0);
         chk("hold_bpr", 32'(BPR), 32'(e_bpr));
         chk("hold_pos", 32'(BPR_POS), 32'(e_pos));
         chk("hold_etc", 32'(ETC), 32'(e_etc));
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      chk("drain_out_valid", 32'(out_valid), 32'd0);
      chk("drain_in_ready", 32'(in_ready), 32'd1);
      $display("txn op=%04h etc=%0d bpr=%06h pos=%06h lat=%0d hold=%0d", op, e_etc, e_bpr, e_pos, first, hold);
   endtask

   initial begin
      reset     = 1'b1;
      in_valid  = 1'b0;
      out_ready = 1'b0;
      operand   = 16'h0000;
      #1;
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_in_ready", 32'(in_ready), 32'd1);
      chk("rst_bpr", 32'(BPR), 32'd0);
      chk("rst_pos", 32'(BPR_POS), 32'd0);
      chk("rst_etc", 32'(ETC), 32'd0);
      @(negedge clk);
      reset = 1'b0;

      run_op(16'h0000, 0);
      run_op(16'h0006, 5);
      run_op(16'hFFFF, 0);
      run_op(16'h5555, 1);

      in_valid = 1'b1;
      operand  = 16'h5555;
      @(posedge clk); #1;
      in_valid = 1'b0;
      repeat (3) @(posedge clk);
      #2;
      reset = 1'b1;
      #1;
      chk("midscan_out_valid", 32'(out_valid), 32'd0);
      chk("midscan_in_ready", 32'(in_ready), 32'd1);
      chk("midscan_bpr", 32'(BPR), 32'd0);
      chk("midscan_pos", 32'(BPR_POS), 32'd0);
      chk("midscan_etc", 32'(ETC), 32'd0);
      @(negedge clk);
      reset = 1'b0;
      run_op(16'h0001, 0);

      for (int i = 0; i < 30; i++) begin
         run_op(16'($urandom), int'($urandom_range(0, 3)));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
